dmem_rsp: RTL and testbench

- Data-memory responder: the far end of the mem_dmem/dmem_mem interface driven by the memory pipeline stage.
- Accepts one word load or store per request, holds a word-wide synchronous storage array, and answers after a programmable number of wait states.
- Responds with a single-cycle dmem_mem_vld pulse. Loads carry read data; stores also get a pulse, as an acknowledge.
- Flags out-of-range accesses through a sticky error bit.

---
 rtl/dmem_rsp.sv | 106 ++++++++++
 tb/tb_dmem_rsp.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_rsp.sv
// rtl/dmem_rsp.sv - data-memory responder with programmable wait states and sticky range error
package mem_dmem_pkg;
    typedef struct packed {
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_dmem_pkt_t;

    typedef struct packed {
        logic [31:0] data;
    } dmem_mem_pkt_t;
endpackage

module dmem_rsp #(
    parameter int DEPTH = 1024,
    parameter int LAT   = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          mem_dmem_vld,
    input  mem_dmem_pkg::mem_dmem_pkt_t   mem_dmem_pkt,
    output logic                          dmem_mem_vld,
    output mem_dmem_pkg::dmem_mem_pkt_t   dmem_mem_pkt,
    output logic                          dmem_err
);
    import mem_dmem_pkg::*;

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    mem_dmem_pkt_t req;
    logic [31:0]   mem [DEPTH];

    mem_dmem_pkt_t cur;
    logic          go_resp;
    logic          oor;
    logic [IW-1:0] idx;

    // With LAT=1 the RESP edge is the accept edge, so the live packet is used there.
    always_comb begin
        cur     = (state == IDLE) ? mem_dmem_pkt : req;
        go_resp = ((state == IDLE) && mem_dmem_vld && (LAT == 1)) ||
                  ((state == WAIT) && (cnt <= 4'd1));
        idx     = cur.addr[IW+1:2];
        oor     = (cur.addr >> (IW + 2)) != 32'd0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            req          <= '0;
            dmem_mem_vld <= 1'b0;
            dmem_mem_pkt <= '0;
            dmem_err     <= 1'b0;
        end else begin
            dmem_mem_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_dmem_vld) begin
                        req   <= mem_dmem_pkt;
                        cnt   <= 4'(LAT - 1);
                        state <= (LAT == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (go_resp) begin
                dmem_mem_vld <= 1'b1;
                if (oor) begin
                    dmem_err <= 1'b1;
                end
                if (cur.rnw) begin
                    dmem_mem_pkt.data <= oor ? 32'd0 : mem[idx];
                end
            end
        end
    end

    // Storage is not reset; gating on resetn keeps a store from landing while reset is held.
    always_ff @(posedge clk) begin
        if (resetn && go_resp && !cur.rnw && !oor) begin
            mem[idx] <= cur.data;
        end
    end

`ifndef SYNTHESIS
    a_single_pulse: assert property (@(posedge clk) disable iff (!resetn)
        dmem_mem_vld |=> !dmem_mem_vld);
    a_pulse_origin: assert property (@(posedge clk) disable iff (!resetn)
        dmem_mem_vld |-> ($past(state) == WAIT || $past(state) == IDLE));
    a_req_held: assert property (@(posedge clk) disable iff (!resetn)
        (state == WAIT) |-> mem_dmem_vld);
    a_lat_range: assert property (@(posedge clk) (LAT >= 1) && (LAT <= 15));
`endif
endmodule

// File: tb/tb_dmem_rsp.sv
// tb/tb_dmem_rsp.sv - scoreboard bench for dmem_rsp at LAT=2, LAT=1 and LAT=15
module tb_dmem_rsp;
    import mem_dmem_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic          vld2, vld1, vld15;
    mem_dmem_pkt_t pkt2, pkt1, pkt15;
    logic          rv2, rv1, rv15;
    dmem_mem_pkt_t rp2, rp1, rp15;
    logic          err2, err1, err15;

    dmem_rsp #(.DEPTH(1024), .LAT(2)) dut (
        .clk(clk), .resetn(resetn), .mem_dmem_vld(vld2), .mem_dmem_pkt(pkt2),
        .dmem_mem_vld(rv2), .dmem_mem_pkt(rp2), .dmem_err(err2));
    dmem_rsp #(.DEPTH(1024), .LAT(1)) dut_l1 (
        .clk(clk), .resetn(resetn), .mem_dmem_vld(vld1), .mem_dmem_pkt(pkt1),
        .dmem_mem_vld(rv1), .dmem_mem_pkt(rp1), .dmem_err(err1));
    dmem_rsp #(.DEPTH(1024), .LAT(15)) dut_l15 (
        .clk(clk), .resetn(resetn), .mem_dmem_vld(vld15), .mem_dmem_pkt(pkt15),
        .dmem_mem_vld(rv15), .dmem_mem_pkt(rp15), .dmem_err(err15));

    typedef struct {
        logic        rnw;
        logic [31:0] data;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [31:0] model [int];

    task automatic issue(input logic rnw, input logic [31:0] addr, input logic [31:0] data,
                         input int exp_edges, input logic last);
        exp_t e;
        int   n;
        bit   in_range;
        in_range = (addr >> 12) == 32'd0;
        e.rnw  = rnw;
        e.data = 32'd0;
        if (rnw && in_range && model.exists(int'(addr[11:2]))) e.data = model[int'(addr[11:2])];
        if (!rnw && in_range) model[int'(addr[11:2])] = data;
        sb.push_back(e);
        pkt2.rnw  = rnw;
        pkt2.addr = addr;
        pkt2.data = data;
        vld2      = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rv2 && n < 40);
        e = sb.pop_front();
        checks++;
        if (!rv2 || n != exp_edges) begin
            errors++;
            $display("FAIL latency addr=%h got %0d edges (pulse=%0b) want %0d", addr, n, rv2, exp_edges);
        end
        if (rv2 && e.rnw) begin
            checks++;
            if (rp2.data !== e.data) begin
                errors++;
                $display("FAIL load_data addr=%h got %h want %h", addr, rp2.data, e.data);
            end
        end
        if (last) vld2 = 1'b0;
    endtask

    task automatic quiet(input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (rv2) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL extra_pulse got %0d pulses want 0", seen);
        end
    endtask

    task automatic test_reset;
        vld2 = 1'b0; vld1 = 1'b0; vld15 = 1'b0;
        pkt2 = '0; pkt1 = '0; pkt15 = '0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rv2 !== 1'b0 || rp2.data !== 32'd0 || err2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got vld=%b data=%h err=%b want 0 0 0", rv2, rp2.data, err2);
        end
        checks++;
        if (rv1 !== 1'b0 || rv15 !== 1'b0 || err1 !== 1'b0 || err15 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_alt got vld1=%b vld15=%b err1=%b err15=%b want 0", rv1, rv15, err1, err15);
        end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        issue(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b1);
        quiet(2);
        issue(1'b1, 32'h0000_0010, 32'h0, 2, 1'b1);
        quiet(2);
    endtask

    task automatic test_alias;
        issue(1'b0, 32'h0000_0013, 32'h1234_5678, 2, 1'b1);
        quiet(2);
        issue(1'b1, 32'h0000_0010, 32'h0, 2, 1'b1);
        quiet(2);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++)
            issue(1'b0, 32'(i * 4), $urandom, (i == 0) ? 2 : 3, 1'b0);
        for (int i = 0; i < 4; i++)
            issue(1'b1, 32'(i * 4), 32'h0, 3, i == 3);
        quiet(4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
        end
    endtask

    task automatic test_out_of_range;
        issue(1'b0, 32'h0000_1000, 32'hFFFF_FFFF, 2, 1'b1);
        checks++;
        if (err2 !== 1'b1) begin
            errors++;
            $display("FAIL oor_err_set got %b want 1", err2);
        end
        quiet(2);
        issue(1'b1, 32'h0000_0000, 32'h0, 2, 1'b1);
        quiet(2);
        issue(1'b1, 32'h0000_1000, 32'h0, 2, 1'b1);
        quiet(2);
        checks++;
        if (err2 !== 1'b1) begin
            errors++;
            $display("FAIL oor_err_sticky got %b want 1", err2);
        end
    endtask

    task automatic test_reset_midop;
        int seen;
        issue(1'b0, 32'h0000_0014, 32'h1111_1111, 2, 1'b1);
        quiet(2);
        pkt2.rnw  = 1'b0;
        pkt2.addr = 32'h0000_0014;
        pkt2.data = 32'hA5A5_A5A5;
        vld2      = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        vld2 = 1'b0;
        seen = rv2 ? 1 : 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (rv2) seen++;
        end
        resetn = 1'b1;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_midop_pulse got %0d pulses want 0", seen);
        end
        checks++;
        if (err2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop_err got %b want 0", err2);
        end
        quiet(2);
        issue(1'b1, 32'h0000_0014, 32'h0, 2, 1'b1);
        quiet(2);
    endtask

    task automatic test_lat1;
        exp_t e;
        int   n;
        pkt1.rnw = 1'b0; pkt1.addr = 32'h0000_0020; pkt1.data = 32'hCAFE_0001; vld1 = 1'b1;
        @(posedge clk); #1;
        vld1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        e.rnw = 1'b1; e.data = 32'hCAFE_0001; sb.push_back(e);
        pkt1.rnw = 1'b1; pkt1.data = 32'h0; vld1 = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rv1 && n < 40);
        e = sb.pop_front();
        vld1 = 1'b0;
        checks++;
        if (!rv1 || n != 1) begin
            errors++;
            $display("FAIL lat1_latency got %0d edges want 1", n);
        end
        checks++;
        if (rp1.data !== e.data) begin
            errors++;
            $display("FAIL lat1_data got %h want %h", rp1.data, e.data);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_lat15;
        exp_t e;
        int   n;
        pkt15.rnw = 1'b0; pkt15.addr = 32'h0000_0024; pkt15.data = 32'h0BAD_F00D; vld15 = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rv15 && n < 40);
        vld15 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        e.rnw = 1'b1; e.data = 32'h0BAD_F00D; sb.push_back(e);
        pkt15.rnw = 1'b1; pkt15.data = 32'h0; vld15 = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rv15 && n < 40);
        e = sb.pop_front();
        vld15 = 1'b0;
        checks++;
        if (!rv15 || n != 15) begin
            errors++;
            $display("FAIL lat15_latency got %0d edges want 15", n);
        end
        checks++;
        if (rp15.data !== e.data) begin
            errors++;
            $display("FAIL lat15_data got %h want %h", rp15.data, e.data);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alias();
        test_back_to_back();
        test_out_of_range();
        test_reset_midop();
        test_lat1();
        test_lat15();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
